shift_ser_ctrl: RTL and testbench



---
 rtl/shift_ser_ctrl.sv | 125 ++++++++++++
 tb/tb_shift_ser_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_ser_ctrl.sv
// Byte serializer controller: loads a byte into an external load/shift-right register,
// then issues one logical right shift per accepted output bit, presenting the register's
// LSB on a valid/ready bit stream.
module shift_ser_ctrl #(
    parameter int unsigned W        = 8,
    parameter logic [2:0]  CMD_LOAD = 3'b001,
    parameter logic [2:0]  CMD_SHR  = 3'b010,
    parameter logic [2:0]  CMD_NOP  = 3'b000
) (
    input  logic         clk,
    input  logic         rst,
    // byte request
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [W-1:0] req_data,
    input  logic [3:0]   req_len,
    input  logic         abort,
    // shift register control
    output logic         sr_en,
    output logic [2:0]   sr_ctrl,
    output logic [W-1:0] sr_din,
    input  logic [W-1:0] sr_dout,
    // serial bit stream
    output logic         bit_valid,
    input  logic         bit_ready,
    output logic         bit_data,
    output logic         bit_last,
    // status
    output logic         busy,
    output logic         frame_done
);

    typedef enum logic [1:0] {StIdle, StLoad, StEmit} state_e;

    state_e       state_q, state_d;
    logic [W-1:0] data_q, data_d;
    logic [3:0]   len_q, len_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         done_d;
    logic [3:0]   len_norm;

    // Only the LSB of the register is observed; the rest is wired in for completeness.
    logic sr_dout_unused;
    assign sr_dout_unused = ^sr_dout[W-1:1];

    // Lengths outside 1..8 mean a full byte.
    assign len_norm = ((req_len == 4'd0) || (req_len > 4'd8)) ? 4'd8 : req_len;

    assign sr_din = data_q;
    assign busy   = (state_q != StIdle);

    // Next-state and output decode; abort overrides every transition.
    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        req_ready = 1'b0;
        sr_en     = 1'b0;
        sr_ctrl   = CMD_NOP;
        bit_valid = 1'b0;
        bit_data  = 1'b0;
        bit_last  = 1'b0;

        unique case (state_q)
            StIdle: begin
                // No request may be taken while an abort is being applied.
                req_ready = !abort;
                if (req_valid && req_ready) begin
                    data_d  = req_data;
                    len_d   = len_norm;
                    cnt_d   = 4'd0;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                sr_en   = !abort;
                sr_ctrl = sr_en ? CMD_LOAD : CMD_NOP;
                state_d = StEmit;
            end
            StEmit: begin
                bit_valid = !abort;
                bit_data  = sr_dout[0];
                bit_last  = (cnt_q == (len_q - 4'd1));
                // Shift only when the sink takes the bit, so a stall keeps bit_data stable.
                sr_en     = bit_ready && !abort;
                sr_ctrl   = sr_en ? CMD_SHR : CMD_NOP;
                if (bit_valid && bit_ready) begin
                    if (bit_last) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (abort) begin
            state_d = StIdle;
            cnt_d   = 4'd0;
            done_d  = 1'b0;
        end
    end

    // State and frame registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            data_q     <= '0;
            len_q      <= 4'd8;
            cnt_q      <= 4'd0;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            frame_done <= done_d;
        end
    end

endmodule

// File: tb/tb_shift_ser_ctrl.sv
// Testbench for shift_ser_ctrl: models the 8-bit load/shift-right register, scoreboards
// the serial bit stream, and runs a vector table plus stall/abort/reset/back-to-back cases.
module tb_shift_ser_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [W-1:0] req_data = '0;
    logic [3:0]   req_len = 4'd0;
    logic         abort = 1'b0;
    logic         sr_en;
    logic [2:0]   sr_ctrl;
    logic [W-1:0] sr_din;
    logic [W-1:0] sr_q = '0;
    logic         bit_valid;
    logic         bit_ready = 1'b1;
    logic         bit_data;
    logic         bit_last;
    logic         busy;
    logic         frame_done;

    shift_ser_ctrl #(.W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_data   (req_data),
        .req_len    (req_len),
        .abort      (abort),
        .sr_en      (sr_en),
        .sr_ctrl    (sr_ctrl),
        .sr_din     (sr_din),
        .sr_dout    (sr_q),
        .bit_valid  (bit_valid),
        .bit_ready  (bit_ready),
        .bit_data   (bit_data),
        .bit_last   (bit_last),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Shift register model; reset does not clear it.
    always @(posedge clk) begin
        if (sr_en) begin
            case (sr_ctrl)
                3'b001:  sr_q <= sr_din;
                3'b010:  sr_q <= {1'b0, sr_q[W-1:1]};
                default: sr_q <= sr_q;
            endcase
        end
    end

    typedef struct packed {
        logic       bit_val;
        logic       last;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   bits_cnt = 0;
    int   load_cnt = 0;
    int   done_cnt = 0;
    int   last_acc = 0;
    int   prev_acc = 0;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: sampled at the falling edge, i.e. describes what the next rising edge does.
    always @(negedge clk) begin
        exp_t e;
        if (!sr_en) check("ctrl_nop_when_idle", int'(sr_ctrl), 0);
        if (sr_en && sr_ctrl == 3'b001) load_cnt++;
        if (req_valid && req_ready) begin
            prev_acc = last_acc;
            last_acc = cyc;
        end
        if (frame_done) done_cnt++;
        if (bit_valid && bit_ready) begin
            bits_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_bit", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("bit_data", int'(bit_data), int'(e.bit_val));
                check("bit_last", int'(bit_last), int'(e.last));
            end
        end
    end

    task automatic push_frame(input logic [7:0] d, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.bit_val = d[i];
            e.last    = (i == n - 1);
            exp_q.push_back(e);
        end
    endtask

    // Waits for the rising edge that accepts the pending request; returns #1 after it.
    task automatic wait_accept();
        bit ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_ready) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("accept_timeout", 0, 1);
    endtask

    task automatic send(input logic [7:0] d, input logic [3:0] l);
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_data  = d;
        req_len   = l;
        wait_accept();
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input int target);
        bit ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (done_cnt >= target) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("done_timeout", 0, 1);
    endtask

    task automatic wait_bits(input int target);
        bit ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (bits_cnt >= target) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("bits_timeout", 0, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, int'(req_ready), 1);
        check({tag, "_sr_en"}, int'(sr_en), 0);
        check({tag, "_sr_ctrl"}, int'(sr_ctrl), 0);
        check({tag, "_sr_din"}, int'(sr_din), 0);
        check({tag, "_bit_valid"}, int'(bit_valid), 0);
        check({tag, "_bit_data"}, int'(bit_data), 0);
        check({tag, "_bit_last"}, int'(bit_last), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_frame_done"}, int'(frame_done), 0);
    endtask

    typedef struct {
        logic [7:0] data;
        logic [3:0] len;
        int         nbits;
        logic [7:0] final_sr;
    } vec_t;

    initial begin
        vec_t vecs[5];
        int   b0, l0, d0;

        // Expected bit count and register contents (data >> bits) worked out by hand.
        vecs[0] = '{8'hA5, 4'd8,  8, 8'h00};
        vecs[1] = '{8'h0F, 4'd3,  3, 8'h01};
        vecs[2] = '{8'h0F, 4'd0,  8, 8'h00};
        vecs[3] = '{8'h0F, 4'd12, 8, 8'h00};
        vecs[4] = '{8'hB6, 4'd1,  1, 8'h5B};

        repeat (3) @(negedge clk);
        check_reset_outputs("in_reset");
        @(posedge clk);
        #1 rst = 1'b0;

        // Vector table: one frame each with bit_ready held high.
        foreach (vecs[k]) begin
            b0 = bits_cnt;
            l0 = load_cnt;
            d0 = done_cnt;
            push_frame(vecs[k].data, vecs[k].nbits);
            send(vecs[k].data, vecs[k].len);
            wait_done(d0 + 1);
            check("vec_bits", bits_cnt - b0, vecs[k].nbits);
            check("vec_loads", load_cnt - l0, 1);
            check("vec_final_sr", int'(sr_q), int'(vecs[k].final_sr));
            check("vec_idle_busy", int'(busy), 0);
            check("vec_idle_valid", int'(bit_valid), 0);
            check("vec_queue_empty", exp_q.size(), 0);
            @(negedge clk);
            check("vec_done_width", int'(frame_done), 0);
        end

        // Stall before bit 3: bit_data must hold and no shift may be issued.
        d0 = done_cnt;
        b0 = bits_cnt;
        push_frame(8'hA5, 8);
        send(8'hA5, 4'd8);
        wait_bits(b0 + 2);
        @(posedge clk);
        #1 bit_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stall_bit_data", int'(bit_data), 1);
            check("stall_sr_en", int'(sr_en), 0);
            check("stall_valid", int'(bit_valid), 1);
        end
        @(posedge clk);
        #1 bit_ready = 1'b1;
        wait_done(d0 + 1);
        check("stall_bits", bits_cnt - b0, 8);
        check("stall_final_sr", int'(sr_q), 0);

        // Abort on the 4th bit: straight to idle, no frame_done, no shift that cycle.
        d0 = done_cnt;
        b0 = bits_cnt;
        push_frame(8'hC3, 8);
        send(8'hC3, 4'd8);
        wait_bits(b0 + 3);
        @(posedge clk);
        #1 abort = 1'b1;
        @(negedge clk);
        check("abort_sr_en", int'(sr_en), 0);
        check("abort_valid", int'(bit_valid), 0);
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        check("abort_busy", int'(busy), 0);
        check("abort_left", exp_q.size(), 5);
        exp_q.delete();
        repeat (3) @(negedge clk);
        check("abort_no_done", done_cnt - d0, 0);
        // Abort while idle blocks a pending request for that cycle.
        @(posedge clk);
        #1;
        abort     = 1'b1;
        req_valid = 1'b1;
        req_data  = 8'h55;
        req_len   = 4'd8;
        @(negedge clk);
        check("abort_idle_ready", int'(req_ready), 0);
        @(posedge clk);
        #1;
        abort     = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        check("abort_idle_busy", int'(busy), 0);
        b0 = bits_cnt;
        push_frame(8'h81, 8);
        send(8'h81, 4'd8);
        wait_done(d0 + 1);
        check("post_abort_bits", bits_cnt - b0, 8);

        // Reset mid-frame, then a fresh frame.
        push_frame(8'hFF, 8);
        b0 = bits_cnt;
        send(8'hFF, 4'd8);
        wait_bits(b0 + 3);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("mid_reset");
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        d0 = done_cnt;
        b0 = bits_cnt;
        push_frame(8'h3C, 8);
        send(8'h3C, 4'd8);
        wait_done(d0 + 1);
        check("post_reset_bits", bits_cnt - b0, 8);

        // Back-to-back requests with req_valid held high.
        d0 = done_cnt;
        b0 = bits_cnt;
        l0 = load_cnt;
        push_frame(8'h01, 8);
        push_frame(8'h80, 8);
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_data  = 8'h01;
        req_len   = 4'd8;
        wait_accept();
        req_data = 8'h80;
        wait_accept();
        req_valid = 1'b0;
        wait_done(d0 + 2);
        check("b2b_spacing", last_acc - prev_acc, 10);
        check("b2b_loads", load_cnt - l0, 2);
        check("b2b_bits", bits_cnt - b0, 16);
        check("b2b_queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
